imem_writer: RTL and testbench

- Loader that fills the instruction memory over a byte stream. The instruction memory is read-only from the datapath side; this block is its write-side counterpart.
- Accepts a program as a stream of 8-bit bytes with a valid/ready handshake, assembles big-endian 32-bit words, and issues one write per word at incrementing word-aligned byte addresses.
- Sits between the boot/programming interface and the instruction memory write port; the processor is held off while busy=1.

---
 rtl/imem_writer.sv | 141 ++++++++++++++
 tb/tb_imem_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_writer.sv
// imem_writer
// Write-side loader for the instruction memory. Takes a program as a stream of
// bytes (valid/ready), packs every four bytes big-endian into a 32-bit word and
// writes it at consecutive word-aligned byte addresses starting at base_addr.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin a load (only looked at while idle)
//   base_addr, len        byte address of first word / number of words, taken with start
//   byte_in, byte_valid   stream byte and its valid
//   byte_ready            a byte is accepted on this edge if byte_valid is also high
//   wr_en/wr_addr/wr_data memory write port; addr/data hold last write while wr_en=0
//   busy                  load in progress (processor held off)
//   done                  one-cycle pulse at end of a load
//   error                 one-cycle pulse when a start is rejected
module imem_writer #(
  parameter int DEPTH = 256,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Range check width: 30-bit word index plus LEN_W-bit count cannot overflow.
  localparam int SW = LEN_W + 31;

  logic [1:0]       state_q,      state_d;
  logic [31:0]      cur_addr_q,   cur_addr_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;
  logic [1:0]       cnt_q,        cnt_d;
  logic [23:0]      word_q,       word_d;   // first three bytes of the word, MSB first
  logic [31:0]      wr_addr_q,    wr_addr_d;
  logic [31:0]      wr_data_q,    wr_data_d;
  logic             error_q,      error_d;

  logic [SW-1:0]    end_word;
  logic             range_bad;
  logic             misaligned;

  assign end_word   = SW'(base_addr[31:2]) + SW'(len);
  assign range_bad  = end_word > SW'(DEPTH);
  assign misaligned = base_addr[1:0] != 2'b00;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    error_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (misaligned || range_bad) begin
            error_d = 1'b1;
          end else if (len == '0) begin
            state_d = S_DONE;
          end else begin
            cur_addr_d   = base_addr;
            words_left_d = len;
            cnt_d        = 2'd0;
            state_d      = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        // byte_ready is high throughout COLLECT, so valid alone means accept.
        if (byte_valid) begin
          cnt_d  = cnt_q + 2'd1;
          word_d = {word_q[15:0], byte_in};
          if (cnt_q == 2'd3) begin
            // Register the write port directly so it holds after the write cycle.
            wr_data_d = {word_q, byte_in};
            wr_addr_d = cur_addr_q;
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        cur_addr_d   = cur_addr_q + 32'd4;
        words_left_d = words_left_q - LEN_W'(1);
        state_d      = (words_left_q == LEN_W'(1)) ? S_DONE : S_COLLECT;
      end
      default: begin // S_DONE
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      error_q      <= error_d;
    end
  end

  // Control outputs are pure state decodes, so reset clears them immediately.
  assign byte_ready = state_q == S_COLLECT;
  assign wr_en      = state_q == S_WRITE;
  assign done       = state_q == S_DONE;
  assign busy       = state_q != S_IDLE;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_writer.sv
module tb_imem_writer;
  localparam int DEPTH = 256;
  localparam int LEN_W = 16;

  logic             clk, rst_n, start, byte_valid;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       byte_in;
  logic             byte_ready, wr_en, busy, done, error;
  logic [31:0]      wr_addr, wr_data;

  imem_writer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  int          checks = 0, failures = 0;
  wr_t         exp_q[$];
  logic [31:0] mdl_addr = '0, mdl_data = '0;       // last write per model
  logic [31:0] dut_last_addr = '0, dut_last_data = '0;
  bit          prev_last = 0, len0_pend = 0, toggle = 0;
  int          done_cnt = 0, exp_done_cnt = 0, err_cnt = 0, exp_err_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the write-list model.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      chk("rdy_wr_excl", 32'(byte_ready & wr_en), 32'd0);
      chk("busy_cover", 32'((byte_ready | wr_en | done) & ~busy), 32'd0);
      if (done) begin
        chk("done_timing", 32'(prev_last | len0_pend), 32'd1);
        len0_pend = 0;
        done_cnt++;
      end
      if (error) err_cnt++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wr addr=%h data=%h", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
          mdl_addr = e.a; mdl_data = e.d;
          dut_last_addr = wr_addr; dut_last_data = wr_data;
        end
      end else begin
        chk("hold_addr", wr_addr, mdl_addr);
        chk("hold_data", wr_data, mdl_data);
      end
      prev_last = wr_en && (exp_q.size() == 0);
    end
  end

  task automatic start_load(logic [31:0] b, logic [LEN_W-1:0] ln, bit exp_err, bit ignored);
    @(negedge clk);
    start = 1'b1; base_addr = b; len = ln;
    if (!exp_err && !ignored && ln == 0) len0_pend = 1;
    if (exp_err) exp_err_cnt++;
    @(negedge clk);
    start = 1'b0;
    chk("error", 32'(error), 32'(exp_err));
    chk("busy_after_start", 32'(busy), 32'(!exp_err));
    if (!exp_err && !ignored) chk("rdy_after_start", 32'(byte_ready), 32'(ln != 0));
  endtask

  task automatic feed_byte(logic [7:0] b, int mode);
    bit ok = 0;
    bit v;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       begin toggle = ~toggle; v = toggle; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_in = b; byte_valid = v;
      if (v && byte_ready) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL byte_accept_timeout byte=%h", b);
    end
  endtask

  task automatic end_bytes();
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int c = 0; c < 30 && !idle; c++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    if (!idle) begin
      checks++; failures++;
      $display("FAIL idle_timeout busy=%b", busy);
    end
  endtask

  // Full accepted load: model expects writes at base+4*i of the words sent.
  task automatic load(logic [31:0] b, int ln, int mode, logic [31:0] first);
    logic [31:0] w[$];
    for (int i = 0; i < ln; i++) begin
      w.push_back(i == 0 ? first : $urandom);
      exp_q.push_back('{b + 32'(4 * i), w[i]});
    end
    start_load(b, LEN_W'(ln), 0, 0);
    exp_done_cnt++;
    foreach (w[i]) for (int k = 0; k < 4; k++) feed_byte(w[i][31 - 8*k -: 8], mode);
    if (ln > 0) end_bytes();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] b, w0, w1;
    int ln, r;
    bit rej;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; byte_in = '0; byte_valid = 1'b0;
    #12;
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single word.
    load(32'h0, 1, 0, 32'h2008_0005);
    chk("t1_addr_lit", dut_last_addr, 32'h0);
    chk("t1_data_lit", dut_last_data, 32'h2008_0005);

    // Multi-word with every-other-cycle valid.
    load(32'h10, 3, 1, $urandom);
    chk("t2_last_addr_lit", dut_last_addr, 32'h18);

    // Rejects and boundary.
    start_load(32'h6, 1, 1, 0);
    @(negedge clk); chk("rej_busy_stays0", 32'(busy), 32'd0);
    start_load(32'h3F8, 3, 1, 0);
    load(32'h3F8, 2, 0, $urandom);
    chk("edge_last_addr_lit", dut_last_addr, 32'h3FC);

    // len == 0.
    load(32'h20, 0, 0, 32'h0);

    // start during COLLECT is ignored.
    w0 = $urandom; w1 = $urandom;
    exp_q.push_back('{32'h100, w0}); exp_q.push_back('{32'h104, w1});
    start_load(32'h100, 2, 0, 0);
    exp_done_cnt++;
    for (int k = 0; k < 4; k++) feed_byte(w0[31 - 8*k -: 8], 0);
    for (int k = 0; k < 2; k++) feed_byte(w1[31 - 8*k -: 8], 0);
    end_bytes();
    start_load(32'h6, 1, 0, 1);
    for (int k = 2; k < 4; k++) feed_byte(w1[31 - 8*k -: 8], 0);
    end_bytes();
    wait_idle();
    chk("ign_last_addr_lit", dut_last_addr, 32'h104);

    // Reset mid-word: partial word dropped.
    start_load(32'h80, 2, 0, 0);
    feed_byte(8'h11, 0); feed_byte(8'h22, 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready", 32'(byte_ready), 32'd0);
    chk("mrst_wr_en", 32'(wr_en), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_wr_addr", wr_addr, 32'd0);
    chk("mrst_wr_data", wr_data, 32'd0);
    byte_valid = 1'b0;
    exp_q.delete(); mdl_addr = '0; mdl_data = '0; prev_last = 0;
    @(negedge clk); rst_n = 1'b1;
    load(32'h40, 1, 0, 32'hAC01_0004);
    chk("post_rst_addr_lit", dut_last_addr, 32'h40);
    chk("post_rst_data_lit", dut_last_data, 32'hAC01_0004);

    // Randomised loads.
    for (int it = 0; it < 14; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        b = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))}; ln = 1;
      end else if (r == 1) begin
        b = 32'($urandom_range(250, 255)) * 4; ln = 10;
      end else begin
        b = 32'($urandom_range(0, 250)) * 4; ln = $urandom_range(0, 4);
      end
      rej = (b % 4 != 0) || (b / 4 + 32'(ln) > DEPTH);
      if (rej) start_load(b, LEN_W'(ln), 1, 0);
      else     load(b, ln, $urandom_range(0, 2), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(exp_done_cnt));
    chk("error_count", 32'(err_cnt), 32'(exp_err_cnt));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
